trap_ctrl: RTL
==============

// Module: trap_ctrl
// PURPOSE
//  Machine-mode trap responder: consumes the CPU's per-retire exception vector and mret, and owns mtvec/mepc/mcause.
//  On ECALL/EBREAK it saves state, then issues a one-cycle PC redirect to mtvec; on mret it redirects to mepc.
//  Fatal exceptions, or a trap with mtvec==0 (no handler installed), drive a sticky halt.
//  Sits between CPU and PC, alongside the top-level run/halt monitor.
// PARAMETERS
//  DATA_WIDTH  64  width of PC and CSR data
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous, active-high reset
//  valid_i        in   1           instruction retiring this cycle; exceptions_i/mret_i/pc_i qualified by it
//  exceptions_i   in   8           [0] fetch err, [1] decode err, [2] anomaly, [3] ECALL, [4] EBREAK, [7:5] ignored
//  mret_i         in   1           retiring instruction is MRET
//  pc_i           in   DATA_WIDTH  PC of retiring instruction
//  csr_we_i       in   1           CSR write strobe
//  csr_addr_i     in   12          CSR address: 0x305 mtvec, 0x341 mepc, 0x342 mcause
//  csr_wdata_i    in   DATA_WIDTH  CSR write data
//  csr_rdata_o    out  DATA_WIDTH  combinational read of csr_addr_i; 0 for unmapped addresses
//  stall_o        out  1           hold PC; high whenever state != RUN
//  redirect_o     out  1           one-cycle pulse: PC loads redirect_pc_o
//  redirect_pc_o  out  DATA_WIDTH  redirect target; 0 when redirect_o low
//  halt_o         out  1           sticky halt, cleared only by rst
// BEHAVIOUR
//  Reset: state=RUN; mtvec=mepc=mcause=0; stall_o=redirect_o=halt_o=0; redirect_pc_o=0.
//  FSM states: RUN, ENTER, RETURN, HALT.
//  RUN, valid_i=1, evaluated by priority (first match wins):
//   1. any of exceptions_i[2:0] -> mcause=1 if bit0, else 2; mepc=pc_i; go HALT.
//   2. ECALL (bit3) -> mcause=11; mepc=pc_i; target=mtvec; go ENTER. EBREAK in the same cycle is ignored.
//   3. EBREAK (bit4) -> mcause=3; mepc=pc_i; target=mtvec; go ENTER.
//   4. mret_i -> target=mepc; go RETURN.
//   5. otherwise -> stay in RUN.
//  Target capture:
//   - target is the mtvec/mepc value before any same-cycle CSR write.
//   - target is registered at the detection cycle N.
//  ENTER / RETURN (cycle N+1):
//   - redirect_o=1, redirect_pc_o=target; go RUN at N+2.
//   - ENTER with target==0: redirect_o stays 0; go HALT instead.
//  Redirect latency: exactly 1 cycle after detection. stall_o is high for exactly 1 cycle per trap or mret.
//  HALT: absorbing; stall_o=1 and halt_o=1 permanently. valid_i and CSR writes are ignored.
//  valid_i is ignored in ENTER, RETURN and HALT.
//  mtvec: bits[1:0] forced 0 on write (direct mode only).
//  mepc: bits[1:0] forced 0 on both CSR write and trap save.
//  mcause: write stores the full csr_wdata_i.
//  CSR write in the same cycle as trap detection:
//   - the trap's mepc/mcause update wins; the write to those two CSRs is dropped.
//   - an mtvec write still commits, but does not affect the captured target.
//  rst in any state returns to reset values on the next edge. An in-flight redirect is cancelled: no pulse appears.
// TESTING
//  T1 reset: hold rst 2 cycles -> all outputs 0, csr_rdata_o=0 at 0x305/0x341/0x342.
//  T2 ECALL: write mtvec=0x8000_0103; valid+ECALL at pc 0x8000_0010
//     -> next cycle redirect_o=1, redirect_pc_o=0x8000_0100, stall_o=1
//     -> mepc=0x8000_0010, mcause=11.
//  T3 MRET: after T2, valid+mret_i -> next cycle redirect_o=1, redirect_pc_o=0x8000_0010; back in RUN one cycle later.
//  T4 fatal: valid with exceptions_i=0x02 at pc 0x8000_0020
//     -> halt_o=1, mcause=2, mepc=0x8000_0020
//     -> later ECALLs and CSR writes change nothing; only rst clears.
//  T5 no handler: mtvec=0, valid+EBREAK -> mcause=3, no redirect pulse, halt_o=1 two cycles after detection.
//  T6 collisions, mtvec=0x8000_0100:
//     - valid+ECALL+EBREAK with same-cycle csr write mtvec=0x9000_0000 -> mcause=11, redirect_pc_o=0x8000_0100, then mtvec reads 0x9000_0000.
//     - separately, rst asserted during ENTER -> no redirect pulse.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap responder: owns mtvec/mepc/mcause. It redirects the PC on ECALL/EBREAK/MRET
// and holds a sticky halt on fatal exceptions or when a trap is taken with no handler installed.
module trap_ctrl #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [7:0]            exceptions_i,
  input  logic                  mret_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  csr_we_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  output logic                  stall_o,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  halt_o
);

  localparam logic [11:0] AddrMtvec  = 12'h305;
  localparam logic [11:0] AddrMepc   = 12'h341;
  localparam logic [11:0] AddrMcause = 12'h342;

  localparam logic [DATA_WIDTH-1:0] AlignMask = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  localparam logic [DATA_WIDTH-1:0] CauseFetch  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] CauseDecode = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] CauseBreak  = DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] CauseEcall  = DATA_WIDTH'(11);

  typedef enum logic [1:0] {
    StRun,
    StEnter,
    StReturn,
    StHalt
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mtvec_q, mtvec_d;
  logic [DATA_WIDTH-1:0] mepc_q, mepc_d;
  logic [DATA_WIDTH-1:0] mcause_q, mcause_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic                  trap_hit;

  // Upper exception bits are reserved and deliberately have no effect.
  logic unused_exc;
  assign unused_exc = ^exceptions_i[7:5];

  always_comb begin
    state_d  = state_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    target_d = target_q;
    trap_hit = 1'b0;

    unique case (state_q)
      StRun: begin
        if (valid_i) begin
          if (|exceptions_i[2:0]) begin
            mcause_d = exceptions_i[0] ? CauseFetch : CauseDecode;
            mepc_d   = pc_i & AlignMask;
            trap_hit = 1'b1;
            state_d  = StHalt;
          end else if (exceptions_i[3]) begin
            mcause_d = CauseEcall;
            mepc_d   = pc_i & AlignMask;
            target_d = mtvec_q;
            trap_hit = 1'b1;
            state_d  = StEnter;
          end else if (exceptions_i[4]) begin
            mcause_d = CauseBreak;
            mepc_d   = pc_i & AlignMask;
            target_d = mtvec_q;
            trap_hit = 1'b1;
            state_d  = StEnter;
          end else if (mret_i) begin
            target_d = mepc_q;
            state_d  = StReturn;
          end
        end
      end
      StEnter:  state_d = (target_q == '0) ? StHalt : StRun;
      StReturn: state_d = StRun;
      StHalt:   state_d = StHalt;
    endcase

    // Trap bookkeeping beats a same-cycle software write to mepc/mcause.
    if (csr_we_i && (state_q != StHalt)) begin
      case (csr_addr_i)
        AddrMtvec:  mtvec_d = csr_wdata_i & AlignMask;
        AddrMepc:   if (!trap_hit) mepc_d = csr_wdata_i & AlignMask;
        AddrMcause: if (!trap_hit) mcause_d = csr_wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    case (csr_addr_i)
      AddrMtvec:  csr_rdata_o = mtvec_q;
      AddrMepc:   csr_rdata_o = mepc_q;
      AddrMcause: csr_rdata_o = mcause_q;
      default:    csr_rdata_o = '0;
    endcase
  end

  // rst gates the pulse so a redirect caught by reset never reaches the PC.
  assign redirect_o    = !rst && ((state_q == StReturn) ||
                                  ((state_q == StEnter) && (target_q != '0)));
  assign redirect_pc_o = redirect_o ? target_q : '0;
  assign stall_o       = (state_q != StRun);
  assign halt_o        = (state_q == StHalt);

endmodule
